// File: rtl/sync_prefetch_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_prefetch_fifo_param
//
// Single-clock first-word-fall-through FIFO. Words are stored in an inferred
// block RAM with a registered read port; a two-stage read pipeline (RAM
// output register, then the prefetch/head register) presents the head word
// before rd_en is asserted. Capacity is 2^DEPTH_WIDTH words in total.
//
// Optional feature: define SYNC_PREFETCH_FIFO_PARITY_EN to store an even
// parity bit with every word and flag mismatches on rd_err. wr_err_inj
// inverts the stored parity bit of the word being written. Without the
// macro the RAM is DATA_WIDTH wide, rd_err is always 0 and wr_err_inj is
// ignored.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush          synchronous clear of all state (same-cycle rd/wr dropped)
//   wr_en/wr_data  write request and word; accepted when wr_vld = 1
//   wr_vld         registered "not full"
//   wr_err_inj     invert stored parity of the written word (parity builds)
//   rd_en          pop request; accepted when rd_vld = 1
//   rd_vld/rd_data head word valid / head word
//   rd_err         parity mismatch on the head word
//   data_cnt       words accepted and not yet popped
//   almost_full    data_cnt >= AFULL_TH
//   almost_empty   data_cnt <= AEMPTY_TH
//   overflow       sticky: write attempted while full
//   underflow      sticky: read attempted while rd_vld = 0
//
// Handshake: a write transfers on a clock edge where wr_en & wr_vld; a read
// transfers on a clock edge where rd_en & rd_vld. Requests without the
// matching valid are dropped and set the sticky error flags.
// ---------------------------------------------------------------------------
module sync_prefetch_fifo_param #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WIDTH = 10,
    parameter int AFULL_TH    = (1 << DEPTH_WIDTH) - 4,
    parameter int AEMPTY_TH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_vld,
    input  logic                   wr_err_inj,
    input  logic                   rd_en,
    output logic                   rd_vld,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_err,
    output logic [DEPTH_WIDTH:0]   data_cnt,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int CW    = DEPTH_WIDTH + 1;
    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0] C_AFULL  = CW'(AFULL_TH);
    localparam logic [CW-1:0] C_AEMPTY = CW'(AEMPTY_TH);
`ifdef SYNC_PREFETCH_FIFO_PARITY_EN
    localparam int RAM_W = DATA_WIDTH + 1;
`else
    localparam int RAM_W = DATA_WIDTH;
`endif

    // Storage and read pipeline
    logic [RAM_W-1:0]       r_mem [DEPTH];
    logic [RAM_W-1:0]       r_ram_q;
    logic [DEPTH_WIDTH-1:0] r_wr_ptr;
    logic [DEPTH_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]          r_ram_cnt;   // words still inside the RAM array
    logic                   r_s1_vld;    // r_ram_q holds a word not yet at the head
    logic                   r_rd_vld;
    logic [DATA_WIDTH-1:0]  r_rd_data;
    logic                   r_rd_err;

    // Status
    logic [CW-1:0]          r_data_cnt;
    logic                   r_wr_vld;
    logic                   r_afull;
    logic                   r_aempty;
    logic                   r_ovf;
    logic                   r_udf;

    logic                   w_wr_acc;
    logic                   w_rd_acc;
    logic                   w_s2_load;
    logic                   w_ram_rd;
    logic [CW-1:0]          w_cnt_nxt;
    logic [CW-1:0]          w_ram_cnt_nxt;
    logic [RAM_W-1:0]       w_wr_word;
    logic [DATA_WIDTH-1:0]  w_q_data;
    logic                   w_q_err;

`ifdef SYNC_PREFETCH_FIFO_PARITY_EN
    // Even parity: the stored bit makes the XOR of the whole entry zero.
    assign w_wr_word = {(^wr_data) ^ wr_err_inj, wr_data};
    assign w_q_data  = r_ram_q[DATA_WIDTH-1:0];
    assign w_q_err   = ^r_ram_q;
`else
    logic w_unused_err_inj;
    assign w_unused_err_inj = wr_err_inj;
    assign w_wr_word = wr_data;
    assign w_q_data  = r_ram_q;
    assign w_q_err   = 1'b0;
`endif

    assign w_wr_acc  = wr_en & r_wr_vld;
    assign w_rd_acc  = rd_en & r_rd_vld;
    // Head register takes the RAM output when it is empty or being popped.
    assign w_s2_load = r_s1_vld & (~r_rd_vld | w_rd_acc);
    // Issue a RAM read whenever a stored word exists and the RAM output
    // register will be free after this edge; this keeps back-to-back pops
    // bubble-free.
    assign w_ram_rd  = (r_ram_cnt != '0) & (~r_s1_vld | w_s2_load);

    always_comb begin
        w_cnt_nxt = r_data_cnt;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_cnt_nxt = r_data_cnt + CW'(1);
            2'b01:   w_cnt_nxt = r_data_cnt - CW'(1);
            default: w_cnt_nxt = r_data_cnt;
        endcase
    end

    always_comb begin
        w_ram_cnt_nxt = r_ram_cnt;
        case ({w_wr_acc, w_ram_rd})
            2'b10:   w_ram_cnt_nxt = r_ram_cnt + CW'(1);
            2'b01:   w_ram_cnt_nxt = r_ram_cnt - CW'(1);
            default: w_ram_cnt_nxt = r_ram_cnt;
        endcase
    end

    // RAM array and registered read port, no reset so they map onto block RAM.
    // A read never targets the address being written: reads only cover words
    // already stored, and a write cannot land while the RAM itself is full.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !flush)
            r_mem[r_wr_ptr] <= w_wr_word;
    end

    always_ff @(posedge clk) begin
        if (w_ram_rd && !flush)
            r_ram_q <= r_mem[r_rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_s1_vld   <= 1'b0;
            r_rd_vld   <= 1'b0;
            r_rd_data  <= '0;
            r_rd_err   <= 1'b0;
            r_data_cnt <= '0;
            r_wr_vld   <= 1'b1;
            r_afull    <= 1'b0;
            r_aempty   <= 1'b1;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_s1_vld   <= 1'b0;
            r_rd_vld   <= 1'b0;
            r_rd_data  <= '0;
            r_rd_err   <= 1'b0;
            r_data_cnt <= '0;
            r_wr_vld   <= 1'b1;
            r_afull    <= 1'b0;
            r_aempty   <= 1'b1;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + DEPTH_WIDTH'(1);
            if (w_ram_rd)
                r_rd_ptr <= r_rd_ptr + DEPTH_WIDTH'(1);

            r_ram_cnt  <= w_ram_cnt_nxt;
            r_data_cnt <= w_cnt_nxt;
            // Flags derive from the next count so they line up with data_cnt.
            r_wr_vld   <= (w_cnt_nxt < C_DEPTH);
            r_afull    <= (w_cnt_nxt >= C_AFULL);
            r_aempty   <= (w_cnt_nxt <= C_AEMPTY);

            if (w_ram_rd)
                r_s1_vld <= 1'b1;
            else if (w_s2_load)
                r_s1_vld <= 1'b0;

            if (w_s2_load) begin
                r_rd_vld  <= 1'b1;
                r_rd_data <= w_q_data;
                r_rd_err  <= w_q_err;
            end else if (w_rd_acc) begin
                r_rd_vld  <= 1'b0;
                r_rd_err  <= 1'b0;
            end

            if (wr_en && !r_wr_vld)
                r_ovf <= 1'b1;
            if (rd_en && !r_rd_vld)
                r_udf <= 1'b1;
        end
    end

    assign wr_vld       = r_wr_vld;
    assign rd_vld       = r_rd_vld;
    assign rd_data      = r_rd_data;
    assign rd_err       = r_rd_err;
    assign data_cnt     = r_data_cnt;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule
